// File: rtl/mpc_kob.sv
// mpc_kob: keep-order buffer, one in-order FIFO of bank ids per upstream channel.
// Each channel's head bank id is offered to the switch box as a req/ack transaction.
`default_nettype none

package mpc_types;
  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
  } channel_req_t;
endpackage

module mpc_kob #(
  parameter int DEPTH    = 4,
  parameter int BANK_LSB = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    u_channel_0_req_valid,
  input  mpc_types::channel_req_t u_channel_0_req,
  input  logic                    u_channel_1_req_valid,
  input  mpc_types::channel_req_t u_channel_1_req,
  input  logic                    u_channel_2_req_valid,
  input  mpc_types::channel_req_t u_channel_2_req,
  output logic                    ch_0_kob_full,
  output logic                    ch_1_kob_full,
  output logic                    ch_2_kob_full,
  output logic                    d_ch_0_swb_req,
  output logic                    d_ch_1_swb_req,
  output logic                    d_ch_2_swb_req,
  output logic [1:0]              d_ch_0_swb_bank_id,
  output logic [1:0]              d_ch_1_swb_bank_id,
  output logic [1:0]              d_ch_2_swb_bank_id,
  input  logic                    d_ch_0_swb_ack,
  input  logic                    d_ch_1_swb_ack,
  input  logic                    d_ch_2_swb_ack
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [2:0] w_valid;
  logic [2:0] w_ack;
  logic [2:0] w_full;
  logic [2:0] w_req;
  logic [1:0] w_bank_in [3];
  logic [1:0] w_bank    [3];

  // Only the bank field of the address is kept; op, wdata and other address bits are dropped.
  logic w_unused_fields;
  assign w_unused_fields = ^{u_channel_0_req, u_channel_1_req, u_channel_2_req};

  assign w_valid      = {u_channel_2_req_valid, u_channel_1_req_valid, u_channel_0_req_valid};
  assign w_ack        = {d_ch_2_swb_ack, d_ch_1_swb_ack, d_ch_0_swb_ack};
  assign w_bank_in[0] = u_channel_0_req.addr[BANK_LSB+1:BANK_LSB];
  assign w_bank_in[1] = u_channel_1_req.addr[BANK_LSB+1:BANK_LSB];
  assign w_bank_in[2] = u_channel_2_req.addr[BANK_LSB+1:BANK_LSB];

  generate
    for (genvar g = 0; g < 3; g++) begin : g_ch
      logic [1:0]       r_mem [DEPTH];
      logic [PTR_W-1:0] r_wr_ptr;
      logic [PTR_W-1:0] r_rd_ptr;
      logic [CNT_W-1:0] r_count;
      logic             w_push;
      logic             w_pop;

      // Full and req come from registered state only, so a same-cycle pop never frees a slot.
      assign w_full[g] = (r_count == CNT_W'(DEPTH));
      assign w_req[g]  = (r_count != '0);
      assign w_push    = w_valid[g] & ~w_full[g];
      assign w_pop     = w_req[g] & w_ack[g];
      assign w_bank[g] = w_req[g] ? r_mem[r_rd_ptr] : 2'b00;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) r_mem[i] <= 2'b00;
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_count  <= '0;
        end else begin
          if (w_push) begin
            r_mem[r_wr_ptr] <= w_bank_in[g];
            r_wr_ptr        <= r_wr_ptr + 1'b1;
          end
          if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
          if (w_push && !w_pop)      r_count <= r_count + 1'b1;
          else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
      end
    end
  endgenerate

  assign ch_0_kob_full      = w_full[0];
  assign ch_1_kob_full      = w_full[1];
  assign ch_2_kob_full      = w_full[2];
  assign d_ch_0_swb_req     = w_req[0];
  assign d_ch_1_swb_req     = w_req[1];
  assign d_ch_2_swb_req     = w_req[2];
  assign d_ch_0_swb_bank_id = w_bank[0];
  assign d_ch_1_swb_bank_id = w_bank[1];
  assign d_ch_2_swb_bank_id = w_bank[2];

endmodule

`default_nettype wire

// File: tb/tb_mpc_kob.sv
// tb_mpc_kob: directed checks of mpc_kob ordering, full/empty boundaries and reset,
// followed by a randomised phase checked against a per-channel queue model.
`default_nettype none

module tb_mpc_kob;

  logic                    clk;
  logic                    rst_n;
  logic                    valid [3];
  logic                    ack   [3];
  mpc_types::channel_req_t req   [3];
  logic                    full  [3];
  logic                    sreq  [3];
  logic [1:0]              bank  [3];

  int checks = 0;
  int errors = 0;

  logic [1:0] mq [3][$];

  mpc_kob #(.DEPTH(4), .BANK_LSB(6)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .u_channel_0_req_valid (valid[0]),
    .u_channel_0_req       (req[0]),
    .u_channel_1_req_valid (valid[1]),
    .u_channel_1_req       (req[1]),
    .u_channel_2_req_valid (valid[2]),
    .u_channel_2_req       (req[2]),
    .ch_0_kob_full         (full[0]),
    .ch_1_kob_full         (full[1]),
    .ch_2_kob_full         (full[2]),
    .d_ch_0_swb_req        (sreq[0]),
    .d_ch_1_swb_req        (sreq[1]),
    .d_ch_2_swb_req        (sreq[2]),
    .d_ch_0_swb_bank_id    (bank[0]),
    .d_ch_1_swb_bank_id    (bank[1]),
    .d_ch_2_swb_bank_id    (bank[2]),
    .d_ch_0_swb_ack        (ack[0]),
    .d_ch_1_swb_ack        (ack[1]),
    .d_ch_2_swb_ack        (ack[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int ch, input logic [1:0] b);
    logic [31:0] a;
    a        = $urandom;
    a[7:6]   = b;
    req[ch]  = '{op: 2'($urandom), addr: a, wdata: $urandom};
    valid[ch] = 1'b1;
  endtask

  task automatic idle_all();
    for (int c = 0; c < 3; c++) begin
      valid[c] = 1'b0;
      ack[c]   = 1'b0;
    end
  endtask

  task automatic check_idle(input string tag);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("%s_req%0d", tag, c), {7'd0, sreq[c]}, 8'd0);
      check($sformatf("%s_bank%0d", tag, c), {6'd0, bank[c]}, 8'd0);
      check($sformatf("%s_full%0d", tag, c), {7'd0, full[c]}, 8'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      valid[c] = 1'($urandom);
      ack[c]   = 1'($urandom);
      req[c]   = '{op: 2'($urandom), addr: $urandom, wdata: $urandom};
    end
    // Reset held with random stimulus
    for (int i = 0; i < 4; i++) begin
      tick();
      for (int c = 0; c < 3; c++) begin
        valid[c] = 1'($urandom);
        ack[c]   = 1'($urandom);
      end
    end
    check_idle("rst");
    idle_all();
    rst_n = 1'b1;
    tick();
    tick();
    check_idle("post_rst");

    // Single request on ch0: addr 0x80 -> bank 2
    req[0]   = '{op: 2'd1, addr: 32'h0000_0080, wdata: 32'hDEAD_BEEF};
    valid[0] = 1'b1;
    check("ch0_no_bypass", {7'd0, sreq[0]}, 8'd0);
    tick();
    valid[0] = 1'b0;
    check("ch0_req", {7'd0, sreq[0]}, 8'd1);
    check("ch0_bank", {6'd0, bank[0]}, 8'd2);
    ack[0] = 1'b1;
    tick();
    ack[0] = 1'b0;
    check("ch0_req_after_pop", {7'd0, sreq[0]}, 8'd0);
    check("ch0_bank_after_pop", {6'd0, bank[0]}, 8'd0);

    // Ack while empty must not underflow
    ack[0] = 1'b1;
    tick();
    ack[0] = 1'b0;
    check("ch0_empty_ack", {7'd0, sreq[0]}, 8'd0);
    set_req(0, 2'd1);
    tick();
    valid[0] = 1'b0;
    check("ch0_req2", {7'd0, sreq[0]}, 8'd1);
    check("ch0_bank2", {6'd0, bank[0]}, 8'd1);
    ack[0] = 1'b1;
    tick();
    ack[0] = 1'b0;
    check("ch0_req2_pop", {7'd0, sreq[0]}, 8'd0);

    // Fill ch1 with banks 0..3, then a dropped 5th push
    for (int b = 0; b < 4; b++) begin
      check($sformatf("ch1_notfull_%0d", b), {7'd0, full[1]}, 8'd0);
      set_req(1, 2'(b));
      tick();
    end
    check("ch1_full", {7'd0, full[1]}, 8'd1);
    set_req(1, 2'd2);
    tick();
    valid[1] = 1'b0;
    check("ch1_full_hold", {7'd0, full[1]}, 8'd1);
    check("ch1_head", {6'd0, bank[1]}, 8'd0);
    ack[1] = 1'b1;
    for (int b = 0; b < 4; b++) begin
      check($sformatf("ch1_drain_req_%0d", b), {7'd0, sreq[1]}, 8'd1);
      check($sformatf("ch1_drain_bank_%0d", b), {6'd0, bank[1]}, 8'(b));
      tick();
      check($sformatf("ch1_drain_full_%0d", b), {7'd0, full[1]}, 8'd0);
    end
    ack[1] = 1'b0;
    check("ch1_empty", {7'd0, sreq[1]}, 8'd0);
    check("ch0_untouched", {7'd0, sreq[0]}, 8'd0);

    // ch2: push+pop with one entry, then push+pop while full
    set_req(2, 2'd3);
    tick();
    set_req(2, 2'd1);
    ack[2] = 1'b1;
    tick();
    ack[2] = 1'b0;
    check("ch2_pp_req", {7'd0, sreq[2]}, 8'd1);
    check("ch2_pp_bank", {6'd0, bank[2]}, 8'd1);
    set_req(2, 2'd0); tick();
    set_req(2, 2'd2); tick();
    set_req(2, 2'd3); tick();
    check("ch2_full", {7'd0, full[2]}, 8'd1);
    set_req(2, 2'd3);
    ack[2] = 1'b1;
    tick();
    valid[2] = 1'b0;
    check("ch2_full_pp_full", {7'd0, full[2]}, 8'd0);
    check("ch2_seq0", {6'd0, bank[2]}, 8'd0);
    tick();
    check("ch2_seq1", {6'd0, bank[2]}, 8'd2);
    tick();
    check("ch2_seq2", {6'd0, bank[2]}, 8'd3);
    tick();
    ack[2] = 1'b0;
    check("ch2_dropped", {7'd0, sreq[2]}, 8'd0);

    // Reset mid-operation with three entries pending on ch0
    set_req(0, 2'd1); tick();
    set_req(0, 2'd2); tick();
    set_req(0, 2'd3); tick();
    valid[0] = 1'b0;
    check("ch0_pending", {7'd0, sreq[0]}, 8'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_req", {7'd0, sreq[0]}, 8'd0);
    check("midrst_full", {7'd0, full[0]}, 8'd0);
    check("midrst_bank", {6'd0, bank[0]}, 8'd0);
    tick();
    rst_n = 1'b1;
    ack[0] = 1'b1;
    tick();
    tick();
    ack[0] = 1'b0;
    check_idle("midrst_rel");

    // Random phase against a queue model per channel
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic m_push [3];
      logic m_pop  [3];
      for (int c = 0; c < 3; c++) begin
        set_req(c, 2'($urandom));
        valid[c] = 1'($urandom);
        ack[c]   = ($urandom_range(0, 3) != 0);
        m_push[c] = valid[c] && (mq[c].size() < 4);
        m_pop[c]  = (mq[c].size() != 0) && ack[c];
      end
      tick();
      for (int c = 0; c < 3; c++) begin
        if (m_pop[c]) void'(mq[c].pop_front());
        if (m_push[c]) mq[c].push_back(req[c].addr[7:6]);
        check($sformatf("rnd_full%0d", c), {7'd0, full[c]}, {7'd0, mq[c].size() == 4});
        check($sformatf("rnd_req%0d", c), {7'd0, sreq[c]}, {7'd0, mq[c].size() != 0});
        check($sformatf("rnd_bank%0d", c), {6'd0, bank[c]},
              (mq[c].size() != 0) ? {6'd0, mq[c][0]} : 8'd0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
